tel_disp: RTL and testbench
===========================

TEL_DISP -- requirements
Module: tel_disp

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays enabled; legal range is 2 or more.
REQ-002 Parameter BLINK_FRAMES, default 32, scan frames per blink half-period.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 statusMsg  in  64  8 ASCII characters from tel; [63:56] is the leftmost character.
REQ-006 sentMsg  in  64  8 ASCII characters from tel, same ordering.
REQ-007 showSent  in  1  level input: 1 displays sentMsg, 0 displays statusMsg.
REQ-008 an  out  8  active-low digit enables; an[7] is the leftmost digit.
REQ-009 seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 dp  out  1  active-low decimal point.

Function
REQ-011 A refresh counter shall count 0..REFRESH_DIV-1, and a 3-bit digit index shall increment when the counter wraps, going 0..7 and then back to 0.
REQ-012 Exactly one an bit shall be low at any time outside reset: an[idx]=0 and all other bits 1.
REQ-013 Digit idx shall show frame[8*idx+7 : 8*idx].
REQ-014 frame (64-bit buffer) shall capture the selected input on the cycle the index wraps 7->0; selection and message changes therefore take effect at the next frame boundary and never mid-frame.
REQ-015 seg shall be a registered decode of the current character and shall change in the same cycle as an, with no glyph from a neighbouring digit shown.
REQ-016 Decode table:
- '0'-'9': standard 7-seg glyphs.
- 'A'-'Z': fixed approximate glyphs.
- 'a'-'z': decoded as the uppercase glyph.
- space (0x20): all segments off.
- DEL (0x7F) and every other code: segment g only ("-").
REQ-017 dp shall be driven low for a full frame on every digit whenever the newly captured frame differs from the previous frame, marking a change, and high otherwise.
REQ-018 A frame counter (0..BLINK_FRAMES-1) shall advance once per frame and toggle a blink phase bit on each wrap.
REQ-019 The decode function and any counters shall not depend on tel's call state, except the blink feature in REQ-024.

Reset
REQ-020 During and after rst:
- an=8'hFF, seg=7'h7F, dp=1;
- refresh counter, digit index, frame counter and blink phase at 0;
- frame = eight spaces (0x2020202020202020).
REQ-021 The first capture shall occur on the first 7->0 wrap after rst deasserts.
REQ-022 rst asserted mid-frame shall blank all outputs immediately (asynchronously), without waiting for a clock edge.

Configuration
REQ-023 Macro TEL_DISP_BLINK_EN controls the ringing blink.
REQ-024 With TEL_DISP_BLINK_EN defined, whenever frame equals "RINGING " and blink phase is 1, an shall be forced to 8'hFF; scanning continues underneath.
REQ-025 Without TEL_DISP_BLINK_EN, the blink phase logic shall be absent and no message blanks the display.

Structure
REQ-026 Package tel_pkg shall hold:
- the 64-bit constants MSG_RINGING and MSG_BLANK;
- the segment-code constants SEG_OFF and SEG_DASH.
REQ-027 The decode logic shall be a purely combinational sub-module, tel_seg_decode, with 8-bit ASCII in and 7-bit seg out, instantiated once.

Verification
All scenarios use REFRESH_DIV=4 and BLINK_FRAMES=2.
REQ-028 Reset release: an cycles FE,FD,FB,...,7F with each value held 4 cycles; seg=7F (blank) throughout the first frame.
REQ-029 statusMsg="CALL    " with showSent=0: after the first wrap, an=7F shows the 'C' glyph, and digits 3..0 show seg=7F.
REQ-030 Toggle showSent mid-frame with sentMsg=" PROJECT": the current frame is unchanged; the next frame shows the new text and dp=0 for that one frame only.
REQ-031 sentMsg byte 0 = 0x0C (invalid) and byte 1 = 0x7F (DEL): both digits show SEG_DASH; lowercase 'e' shows the same glyph as 'E'.
REQ-032 With TEL_DISP_BLINK_EN defined and statusMsg="RINGING ": an is FF for 2 frames, then scans for 2 frames, repeating. Without the macro, an scans continuously.
REQ-033 Assert rst for 1 ns mid-frame: outputs blank at once, and the frame restarts from digit 0 with a blank buffer.

Source files
------------

// File: rtl/tel_pkg.sv
// Shared constants for the telephone status display.
// Messages are 8 ASCII bytes, leftmost character in the top byte.
package tel_pkg;

  localparam logic [63:0] MSG_RINGING = 64'h52494E47494E4720;  // "RINGING "
  localparam logic [63:0] MSG_BLANK   = 64'h2020202020202020;  // eight spaces

  // Active-low segment codes, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  typedef logic [2:0] digitIdxT;

endpackage

// File: rtl/tel_seg_decode.sv
// ASCII to active-low 7-segment decode; lowercase letters reuse the uppercase
// glyphs, space is blank and anything unrecognised renders as a dash.
module tel_seg_decode
  import tel_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [6:0] seg
);

  logic [7:0] upper;

  // Fold lowercase onto uppercase, then look up the glyph
  always_comb begin
    upper = ascii;
    if ((ascii >= 8'h61) && (ascii <= 8'h7A)) begin
      upper = ascii - 8'h20;
    end else begin
      upper = ascii;
    end

    seg = SEG_DASH;
    case (upper)
      8'h20: seg = SEG_OFF;
      8'h30: seg = ~7'h3F;
      8'h31: seg = ~7'h06;
      8'h32: seg = ~7'h5B;
      8'h33: seg = ~7'h4F;
      8'h34: seg = ~7'h66;
      8'h35: seg = ~7'h6D;
      8'h36: seg = ~7'h7D;
      8'h37: seg = ~7'h07;
      8'h38: seg = ~7'h7F;
      8'h39: seg = ~7'h6F;
      8'h41: seg = ~7'h77;
      8'h42: seg = ~7'h7C;
      8'h43: seg = ~7'h39;
      8'h44: seg = ~7'h5E;
      8'h45: seg = ~7'h79;
      8'h46: seg = ~7'h71;
      8'h47: seg = ~7'h3D;
      8'h48: seg = ~7'h76;
      8'h49: seg = ~7'h30;
      8'h4A: seg = ~7'h1E;
      8'h4B: seg = ~7'h75;
      8'h4C: seg = ~7'h38;
      8'h4D: seg = ~7'h37;
      8'h4E: seg = ~7'h54;
      8'h4F: seg = ~7'h3F;
      8'h50: seg = ~7'h73;
      8'h51: seg = ~7'h67;
      8'h52: seg = ~7'h50;
      8'h53: seg = ~7'h6D;
      8'h54: seg = ~7'h78;
      8'h55: seg = ~7'h3E;
      8'h56: seg = ~7'h1C;
      8'h57: seg = ~7'h2A;
      8'h58: seg = ~7'h64;
      8'h59: seg = ~7'h6E;
      8'h5A: seg = ~7'h5B;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/tel_disp.sv
// Eight-digit multiplexed display of the tel status or sent message.
// Define TEL_DISP_BLINK_EN to blink the display while "RINGING " is shown.
module tel_disp
  import tel_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] statusMsg,
  input  logic [63:0] sentMsg,
  input  logic        showSent,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] refreshCnt;
  digitIdxT         digitIdx;
  logic [63:0]      frameBuf;
  logic             frameChanged;
  logic [FRM_W-1:0] frameCnt;
  logic [7:0]       anReg;
  logic [6:0]       segReg;
  logic             dpReg;

  logic             cntWrap;
  logic             frameWrap;
  logic [63:0]      nextFrame;
  logic [7:0]       curChar;
  logic [7:0]       anScan;
  logic [6:0]       decodedSeg;
  logic             blankAll;

  // Scan timing, frame source selection and current character
  always_comb begin
    cntWrap   = (refreshCnt == CNT_LAST);
    frameWrap = cntWrap && (digitIdx == 3'd7);
    nextFrame = showSent ? sentMsg : statusMsg;
    curChar   = frameBuf[{digitIdx, 3'b000} +: 8];
    anScan    = ~(8'h01 << digitIdx);
  end

  tel_seg_decode uDecode (
    .ascii (curChar),
    .seg   (decodedSeg)
  );

  // Refresh counter, digit index, frame capture and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refreshCnt   <= {CNT_W{1'b0}};
      digitIdx     <= 3'd0;
      frameBuf     <= MSG_BLANK;
      frameChanged <= 1'b0;
      frameCnt     <= {FRM_W{1'b0}};
    end else begin
      refreshCnt <= cntWrap ? {CNT_W{1'b0}} : refreshCnt + CNT_W'(1);
      if (cntWrap) begin
        digitIdx <= digitIdx + 3'd1;
      end
      // New text only lands at the 7->0 boundary so a frame is never torn
      if (frameWrap) begin
        frameBuf     <= nextFrame;
        frameChanged <= (nextFrame != frameBuf);
        frameCnt     <= (frameCnt == FRM_LAST) ? {FRM_W{1'b0}} : frameCnt + FRM_W'(1);
      end
    end
  end

`ifdef TEL_DISP_BLINK_EN
  logic blinkPhase;

  // Blink phase flips each time the frame counter wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blinkPhase <= 1'b0;
    end else if (frameWrap && (frameCnt == FRM_LAST)) begin
      blinkPhase <= ~blinkPhase;
    end
  end

  assign blankAll = blinkPhase && (frameBuf == MSG_RINGING);
`else
  assign blankAll = 1'b0;
`endif

  // Outputs are registered from the same index so an and seg move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anReg  <= 8'hFF;
      segReg <= SEG_OFF;
      dpReg  <= 1'b1;
    end else begin
      anReg  <= blankAll ? 8'hFF : anScan;
      segReg <= decodedSeg;
      dpReg  <= ~frameChanged;
    end
  end

  assign an  = anReg;
  assign seg = segReg;
  assign dp  = dpReg;

endmodule

// File: tb/tb_tel_disp.sv
// Directed bench for tel_disp with REFRESH_DIV=4 and BLINK_FRAMES=2.
// Honours TEL_DISP_BLINK_EN when deciding whether RINGING frames blank.
module tb_tel_disp;

  logic        clk;
  logic        rst;
  logic [63:0] statusMsg;
  logic [63:0] sentMsg;
  logic        showSent;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks;
  int errors;
  logic blinkOn;

  localparam logic [63:0] TXT_CALL    = 64'h43414C4C20202020;
  localparam logic [63:0] TXT_PROJECT = 64'h2050524F4A454354;
  localparam logic [63:0] TXT_RINGING = 64'h52494E47494E4720;
  localparam logic [63:0] TXT_MIXED   = 64'h65453039417A7F0C;

  localparam logic [55:0] G_BLANK   = {8{7'h7F}};
  localparam logic [55:0] G_CALL    = {7'h46, 7'h08, 7'h47, 7'h47, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [55:0] G_PROJECT = {7'h7F, 7'h0C, 7'h2F, 7'h40, 7'h61, 7'h06, 7'h46, 7'h07};
  localparam logic [55:0] G_MIXED   = {7'h06, 7'h06, 7'h40, 7'h10, 7'h08, 7'h24, 7'h3F, 7'h3F};
  localparam logic [55:0] G_RINGING = {7'h2F, 7'h4F, 7'h2B, 7'h42, 7'h4F, 7'h2B, 7'h42, 7'h7F};

  tel_disp #(
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .statusMsg (statusMsg),
    .sentMsg   (sentMsg),
    .showSent  (showSent),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full 32-cycle frame, sampled on each falling edge
  task automatic runFrame(input string tag, input logic [55:0] expSeg, input logic expDp,
                          input logic expBlank, input int toggleAt);
    logic [7:0] expAn;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        expAn = expBlank ? 8'hFF : ~(8'h01 << d);
        checkEq($sformatf("%s an d%0d c%0d", tag, d, c), {56'd0, an}, {56'd0, expAn});
        checkEq($sformatf("%s seg d%0d c%0d", tag, d, c), {57'd0, seg}, {57'd0, expSeg[7*d +: 7]});
        checkEq($sformatf("%s dp d%0d c%0d", tag, d, c), {63'd0, dp}, {63'd0, expDp});
        if ((d * 4 + c) == toggleAt) begin
          showSent = 1'b1;
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
`ifdef TEL_DISP_BLINK_EN
    blinkOn   = 1'b1;
`else
    blinkOn   = 1'b0;
`endif
    rst       = 1'b1;
    statusMsg = TXT_CALL;
    sentMsg   = TXT_PROJECT;
    showSent  = 1'b0;

    repeat (3) @(negedge clk);
    checkEq("reset an", {56'd0, an}, 64'hFF);
    checkEq("reset seg", {57'd0, seg}, 64'h7F);
    checkEq("reset dp", {63'd0, dp}, 64'h1);
    rst = 1'b0;

    runFrame("f0 blank", G_BLANK, 1'b1, 1'b0, -1);
    runFrame("f1 call", G_CALL, 1'b0, 1'b0, -1);
    runFrame("f2 call toggle", G_CALL, 1'b1, 1'b0, 13);
    runFrame("f3 project", G_PROJECT, 1'b0, 1'b0, -1);
    sentMsg = TXT_MIXED;
    runFrame("f4 project hold", G_PROJECT, 1'b1, 1'b0, -1);
    showSent  = 1'b0;
    statusMsg = TXT_RINGING;
    runFrame("f5 mixed", G_MIXED, 1'b0, 1'b0, -1);
    runFrame("f6 ring", G_RINGING, 1'b0, blinkOn, -1);
    runFrame("f7 ring", G_RINGING, 1'b1, blinkOn, -1);
    runFrame("f8 ring", G_RINGING, 1'b1, 1'b0, -1);
    runFrame("f9 ring", G_RINGING, 1'b1, 1'b0, -1);

    // Short asynchronous reset pulse part way into a frame
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("async an", {56'd0, an}, 64'hFF);
    checkEq("async seg", {57'd0, seg}, 64'h7F);
    checkEq("async dp", {63'd0, dp}, 64'h1);
    rst = 1'b0;

    runFrame("r0 blank", G_BLANK, 1'b1, 1'b0, -1);
    runFrame("r1 ring", G_RINGING, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
